// File: rtl/nvm_lif_neuron_array.sv
// nvm_lif_neuron_array: leaky integrate-and-fire output layer with per-picture spike counting
// and an argmax scan that hands the winning class to the host.
module nvm_lif_neuron_array #(
    parameter int NUM_NEURONS = 4,
    parameter int STIM_W      = 16,
    parameter int POT_W       = 16,
    parameter int CNT_W       = 8,
    parameter int IDX_W       = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [STIM_W-1:0] stimuli,
    input  logic [NUM_NEURONS-1:0]   connection,
    input  logic                     enable,
    input  logic                     step_done,
    input  logic                     picture_done,
    input  logic signed [POT_W-1:0]  threshold,
    input  logic [3:0]               leak_shift,
    output logic [NUM_NEURONS-1:0]   spike_o,
    output logic [IDX_W-1:0]         class_o,
    output logic                     class_none_o,
    output logic                     class_valid,
    input  logic                     class_ready,
    output logic                     busy_o,
    output logic                     overrun_o
);
    localparam int EW = POT_W + 2;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    function automatic logic signed [POT_W-1:0] sat(input logic signed [EW-1:0] v);
        logic signed [EW-1:0] hi, lo;
        hi = {3'b000, {(POT_W-1){1'b1}}};
        lo = {3'b111, {(POT_W-1){1'b0}}};
        return v > hi ? hi[POT_W-1:0] : v < lo ? lo[POT_W-1:0] : v[POT_W-1:0];
    endfunction

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q, best_q;
    logic [CNT_W-1:0]        best_cnt_q;
    logic signed [POT_W-1:0] pot_q [NUM_NEURONS];
    logic signed [POT_W-1:0] pot_d [NUM_NEURONS];
    logic [CNT_W-1:0]        cnt_q [NUM_NEURONS];
    logic [CNT_W-1:0]        cnt_d [NUM_NEURONS];
    logic [CNT_W-1:0]        snap_q [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]  fire;

    for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_n
        logic signed [POT_W-1:0] a;
        logic signed [EW-1:0]    ae, b;
        assign a  = (enable && connection[i]) ? sat(EW'(pot_q[i]) + EW'(stimuli)) : pot_q[i];
        assign ae = EW'(a);
        assign b  = (leak_shift != 4'd0) ? ae - (ae >>> leak_shift) : ae;
        assign fire[i]  = step_done && (b >= EW'(threshold));
        assign pot_d[i] = !step_done ? a : fire[i] ? sat(b - EW'(threshold)) : b[POT_W-1:0];
        assign cnt_d[i] = (fire[i] && cnt_q[i] != '1) ? cnt_q[i] + 1'b1 : cnt_q[i];
    end

    // picture_done clears the live state but the snapshot still sees this cycle's spikes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_o <= '0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                pot_q[k]  <= '0;
                cnt_q[k]  <= '0;
                snap_q[k] <= '0;
            end
        end else begin
            spike_o <= fire;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                pot_q[k] <= picture_done ? '0 : pot_d[k];
                cnt_q[k] <= picture_done ? '0 : cnt_d[k];
                if (picture_done && state_q == IDLE) snap_q[k] <= cnt_d[k];
            end
        end
    end

    assign busy_o = state_q != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            best_q       <= '0;
            best_cnt_q   <= '0;
            class_o      <= '0;
            class_none_o <= 1'b0;
            class_valid  <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            overrun_o <= picture_done && state_q != IDLE;
            case (state_q)
                IDLE: if (picture_done) begin
                    state_q    <= SCAN;
                    idx_q      <= '0;
                    best_q     <= '0;
                    best_cnt_q <= '0;
                end
                SCAN: begin
                    if (snap_q[idx_q] > best_cnt_q) begin
                        best_cnt_q <= snap_q[idx_q];
                        best_q     <= idx_q;
                    end
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IDX_W'(NUM_NEURONS - 1)) state_q <= DONE;
                end
                DONE: if (class_valid && class_ready) begin
                    class_valid <= 1'b0;
                    state_q     <= IDLE;
                end else if (!class_valid) begin
                    class_valid  <= 1'b1;
                    class_o      <= best_q;
                    class_none_o <= best_cnt_q == '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nvm_lif_neuron_array.sv
// tb_nvm_lif_neuron_array: directed scenarios plus random traffic checked cycle by cycle
// against an integer behavioural model of the neuron layer and class handshake.
module tb_nvm_lif_neuron_array;
    localparam int N = 4, SW = 16, PW = 16, CW = 8, IW = 2;
    localparam int PMAX = (1 << (PW - 1)) - 1, PMIN = -(1 << (PW - 1)), CMAX = (1 << CW) - 1;

    logic                 clk = 1'b0, rst = 1'b1;
    logic signed [SW-1:0] stimuli = '0;
    logic [N-1:0]         connection = '0;
    logic                 enable = 1'b0, step_done = 1'b0, picture_done = 1'b0, class_ready = 1'b0;
    logic signed [PW-1:0] threshold = 16'sd100;
    logic [3:0]           leak_shift = 4'd0;
    logic [N-1:0]         spike_o;
    logic [IW-1:0]        class_o;
    logic                 class_none_o, class_valid, busy_o, overrun_o;

    nvm_lif_neuron_array #(.NUM_NEURONS(N), .STIM_W(SW), .POT_W(PW), .CNT_W(CW), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .stimuli(stimuli), .connection(connection), .enable(enable),
        .step_done(step_done), .picture_done(picture_done), .threshold(threshold),
        .leak_shift(leak_shift), .spike_o(spike_o), .class_o(class_o), .class_none_o(class_none_o),
        .class_valid(class_valid), .class_ready(class_ready), .busy_o(busy_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    int checks = 0, fails = 0;
    int pot_m [N], cnt_m [N];
    int m_cd, m_class;
    bit m_busy, m_valid, m_none, ovr_m;
    logic [N-1:0] spike_m;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        return v > PMAX ? PMAX : v < PMIN ? PMIN : v;
    endfunction

    task automatic check_outputs();
        check("spike_o", spike_o, spike_m);
        check("busy_o", busy_o, m_busy);
        check("overrun_o", overrun_o, ovr_m);
        check("class_valid", class_valid, m_valid);
        if (m_valid) begin
            check("class_o", class_o, m_class);
            check("class_none_o", class_none_o, m_none);
        end
    endtask

    task automatic model_reset();
        foreach (pot_m[i]) begin pot_m[i] = 0; cnt_m[i] = 0; end
        m_busy = 0; m_valid = 0; m_none = 0; ovr_m = 0; m_cd = 0; m_class = 0; spike_m = '0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        enable = 1'b0; step_done = 1'b0; picture_done = 1'b0;
        model_reset();
        #1;
        check_outputs();
        check("rst class_o", class_o, 0);
        check("rst class_none_o", class_none_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cyc(input int stim, input logic [N-1:0] conn, input bit en, input bit sd,
                       input bit pd, input bit rdy);
        int a, b, t, best;
        bit old_busy;
        logic [31:0] sv;
        sv = stim;
        stimuli = sv[SW-1:0]; connection = conn; enable = en;
        step_done = sd; picture_done = pd; class_ready = rdy;
        @(posedge clk);
        t = threshold;
        for (int i = 0; i < N; i++) begin
            a = (en && conn[i]) ? clamp(pot_m[i] + stim) : pot_m[i];
            spike_m[i] = 1'b0;
            if (sd) begin
                b = (leak_shift != 0) ? a - (a >>> leak_shift) : a;
                if (b >= t) begin
                    spike_m[i] = 1'b1;
                    pot_m[i] = clamp(b - t);
                    cnt_m[i] = cnt_m[i] < CMAX ? cnt_m[i] + 1 : CMAX;
                end else pot_m[i] = b;
            end else pot_m[i] = a;
        end
        old_busy = m_busy;
        ovr_m = pd && old_busy;
        if (m_valid && rdy) begin
            m_valid = 0; m_busy = 0;
        end else if (m_busy && !m_valid) begin
            m_cd--;
            if (m_cd == 0) m_valid = 1;
        end
        if (pd && !old_busy) begin
            m_busy = 1; m_cd = N + 1; best = 0; m_class = 0;
            for (int i = 0; i < N; i++) if (cnt_m[i] > best) begin best = cnt_m[i]; m_class = i; end
            m_none = best == 0;
        end
        if (pd) foreach (pot_m[i]) begin pot_m[i] = 0; cnt_m[i] = 0; end
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) cyc(0, '0, 0, 0, 0, rdy);
    endtask

    initial begin
        int cnts [N];
        do_reset();
        // T1: 3x40 into neuron 0, fire at 100 leaves 20
        threshold = 16'sd100; leak_shift = 4'd0;
        repeat (3) cyc(40, 4'b0001, 1, 0, 0, 0);
        cyc(0, '0, 0, 1, 0, 0);
        cyc(0, '0, 0, 0, 0, 0);
        // T2: 64 with leak 2 -> 48, then threshold 48 must just fire
        cyc(44, 4'b0001, 1, 0, 0, 0);
        threshold = 16'sd1000; leak_shift = 4'd2;
        cyc(0, '0, 0, 1, 0, 0);
        threshold = 16'sd48; leak_shift = 4'd0;
        cyc(0, '0, 0, 1, 0, 0);
        // T3: positive and negative saturation
        repeat (5) cyc(30000, 4'b1111, 1, 0, 0, 0);
        threshold = 16'sd32767;
        cyc(0, '0, 0, 1, 0, 0);
        repeat (5) cyc(-30000, 4'b1111, 1, 0, 0, 0);
        threshold = -16'sd32767;
        cyc(0, '0, 0, 1, 0, 0);
        cyc(0, '0, 0, 0, 1, 1);
        idle(N + 3, 1);
        // T4: counts {3,7,7,2}, host stalls then accepts
        threshold = 16'sd1;
        cnts = '{3, 7, 7, 2};
        for (int k = 0; k < 7; k++) begin
            logic [N-1:0] m;
            for (int i = 0; i < N; i++) m[i] = k < cnts[i];
            cyc(1, m, 1, 1, 0, 0);
        end
        cyc(0, '0, 0, 0, 1, 0);
        idle(N + 11, 0);
        idle(2, 1);
        // T5: empty picture
        cyc(0, '0, 0, 0, 1, 0);
        idle(N + 2, 0);
        idle(2, 1);
        // counter saturation: neuron 3 fires 260 times, neuron 0 ten times
        repeat (260) cyc(1, 4'b1000, 1, 1, 0, 0);
        repeat (10) cyc(1, 4'b0001, 1, 1, 0, 0);
        cyc(0, '0, 0, 0, 1, 0);
        idle(N + 2, 1);
        // T6: simultaneous step/picture, overrun during scan, reset during DONE
        threshold = 16'sd100;
        cyc(150, 4'b0100, 1, 0, 0, 0);
        cyc(0, '0, 0, 1, 1, 0);
        cyc(0, '0, 0, 0, 1, 0);
        idle(N + 3, 0);
        do_reset();
        idle(2, 1);
        // random traffic
        for (int k = 0; k < 3000; k++) begin
            int s;
            if ($urandom_range(49) == 0) threshold = PW'($urandom_range(2000) + 20);
            if ($urandom_range(99) == 0) leak_shift = 4'($urandom_range(5));
            s = ($urandom_range(15) == 0) ? ($urandom_range(1) ? 30000 : -30000)
                                          : int'($urandom_range(5000)) - 2000;
            cyc(s, 4'($urandom), $urandom_range(3) != 0, $urandom_range(3) == 0,
                $urandom_range(19) == 0, $urandom_range(2) != 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
